// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//   Fetch stage sitting directly after program_counter. Issues instruction
//   memory reads at the current PC, computes the next PC, and buffers returned
//   {pc, instr} pairs in an in-order show-ahead FIFO for decode. Responses to
//   requests issued before a branch/jump redirect are counted and discarded.
//
// Ports
//   clk            in   clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   pc_i           in   current PC (program_counter.data_o)
//   pc_next_o      out  next PC (program_counter.data_in)
//   redirect_i     in   branch/jump taken, restart at redirect_pc_i
//   redirect_pc_i  in   redirect target (forced word aligned)
//   imem_req_o     out  read request valid
//   imem_addr_o    out  read address (= pc_i)
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   read data valid, one per accepted request, in order
//   imem_rdata_i   in   read data
//   instr_valid_o  out  FIFO head valid
//   instr_o        out  FIFO head instruction
//   instr_pc_o     out  FIFO head PC
//   instr_ready_i  in   decode accepts head this cycle
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_next_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_SUM = (CW+1)'(FIFO_DEPTH);

  // PC-tag queue: PC of every accepted, not yet returned request
  logic [XLEN-1:0] r_tag_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_tag_wptr;
  logic [AW-1:0]   r_tag_rptr;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  // Output FIFO
  logic [XLEN-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0]   r_fifo_wptr;
  logic [AW-1:0]   r_fifo_rptr;
  logic [CW-1:0]   r_fifo_cnt;
  logic [XLEN-1:0] r_last_instr;
  logic [XLEN-1:0] r_last_pc;

  logic            w_redirect;
  logic [CW:0]     w_sum;
  logic            w_credit;
  logic            w_req;
  logic            w_accept;
  logic            w_rvalid;
  logic            w_fifo_empty;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_tag;
  logic [XLEN-1:0] w_head_instr;
  logic [XLEN-1:0] w_head_pc;
  logic [1:0]      w_unused_redirect_lsb;

  // Everything combinational is gated by reset so outputs drop immediately
  // on reset assertion, without waiting for a clock edge.
  assign w_redirect   = reset_n && redirect_i;
  assign w_sum        = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit     = (w_sum < DEPTH_SUM);
  assign w_req        = reset_n && !redirect_i && w_credit;
  assign w_accept     = w_req && imem_gnt_i;
  // A response with nothing outstanding is a protocol violation and ignored.
  assign w_rvalid     = reset_n && imem_rvalid_i && (r_outstanding != '0);
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_push       = w_rvalid && (r_drop_cnt == '0) && !w_redirect;
  assign w_pop        = !w_fifo_empty && instr_ready_i && !w_redirect;
  assign w_tag        = r_tag_mem[r_tag_rptr];
  assign w_head_instr = r_fifo_instr[r_fifo_rptr];
  assign w_head_pc    = r_fifo_pc[r_fifo_rptr];
  assign w_unused_redirect_lsb = redirect_pc_i[1:0];

  assign imem_req_o    = w_req;
  assign imem_addr_o   = pc_i;
  assign instr_valid_o = !w_fifo_empty;
  // When empty, present the last head that was shown rather than stale storage.
  assign instr_o       = w_fifo_empty ? r_last_instr : w_head_instr;
  assign instr_pc_o    = w_fifo_empty ? r_last_pc    : w_head_pc;

  always_comb begin
    pc_next_o = pc_i;
    if (w_redirect) begin
      pc_next_o = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (w_accept) begin
      pc_next_o = pc_i + XLEN'(4);
    end
  end

  // Request bookkeeping: tag pointers, outstanding count, stale-drop count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_accept) r_tag_wptr <= r_tag_wptr + 1'b1;
      if (w_rvalid) r_tag_rptr <= r_tag_rptr + 1'b1;
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rvalid);
      // Every request still in flight at redirect belongs to the old path,
      // including any already being dropped; a response arriving in the
      // redirect cycle itself is discarded here as well.
      if (w_redirect) begin
        r_drop_cnt <= r_outstanding - CW'(w_rvalid);
      end else if (w_rvalid && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag_mem[r_tag_wptr] <= pc_i;
  end

  // Output FIFO control. Credit accounting guarantees a push never overflows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_wptr  <= '0;
      r_fifo_rptr  <= '0;
      r_fifo_cnt   <= '0;
      r_last_instr <= '0;
      r_last_pc    <= '0;
    end else begin
      if (!w_fifo_empty) begin
        r_last_instr <= w_head_instr;
        r_last_pc    <= w_head_pc;
      end
      if (w_redirect) begin
        r_fifo_wptr <= '0;
        r_fifo_rptr <= '0;
        r_fifo_cnt  <= '0;
      end else begin
        if (w_push) r_fifo_wptr <= r_fifo_wptr + 1'b1;
        if (w_pop)  r_fifo_rptr <= r_fifo_rptr + 1'b1;
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_fifo_wptr] <= imem_rdata_i;
      r_fifo_pc[r_fifo_wptr]    <= w_tag;
    end
  end

  rvalid_needs_outstanding : assert property (
    @(posedge clk) disable iff (!reset_n) imem_rvalid_i |-> (r_outstanding != '0));

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_reg;
  logic [31:0] pc_next_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i  = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        mem_hold;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mem_q[$];

  instr_fetch_stage #(.XLEN(32), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_i          (pc_reg),
    .pc_next_o     (pc_next_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h0000_0013;
    return a + 32'h1000_0000;
  endfunction

  // program_counter model
  always @(posedge clk) begin
    if (pc_load) pc_reg <= pc_load_val;
    else         pc_reg <= pc_next_o;
  end

  // Instruction memory: one-cycle latency, in order, stallable by mem_hold
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_q.delete();
      imem_rvalid_i <= 1'b0;
      imem_rdata_i  <= '0;
    end else begin
      if (imem_req_o && imem_gnt_i) mem_q.push_back(imem_addr_o);
      if (!mem_hold && mem_q.size() != 0) begin
        imem_rvalid_i <= 1'b1;
        imem_rdata_i  <= mem_word(mem_q.pop_front());
      end else begin
        imem_rvalid_i <= 1'b0;
      end
    end
  end

  // Scoreboard monitor: compare every instruction decode consumes
  always @(negedge clk) begin
    if (reset_n && instr_valid_o && instr_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected actual pc=%h instr=%h required=none", instr_pc_o, instr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr_pc_o !== e.pc || instr_o !== e.instr) begin
          errors++;
          $display("FAIL mon_pair actual pc=%h instr=%h required pc=%h instr=%h",
                   instr_pc_o, instr_o, e.pc, e.instr);
        end
      end
    end
  end

  task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc;
    reset_n       = 1'b0;
    pc_load       = 1'b1;
    pc_load_val   = 32'h10;
    mem_hold      = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    instr_ready_i = 1'b0;
    #2;
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_instr_pc", instr_pc_o, 32'h0);
    repeat (3) cyc();
    chk("rst_pc_next", pc_next_o, 32'h10);

    // 1: single fetch at 0x10
    cyc(); reset_n = 1'b1; pc_load = 1'b0; imem_gnt_i = 1'b1; #1;
    chk("t1_req", 32'(imem_req_o), 32'h1);
    chk("t1_addr", imem_addr_o, 32'h10);
    chk("t1_pc_next", pc_next_o, 32'h14);
    expect_instr(32'h10, 32'h13);
    cyc(); imem_gnt_i = 1'b0; #1;
    chk("t1_pc_hold", pc_next_o, 32'h14);
    chk("t1_valid_lat", 32'(instr_valid_o), 32'h0);
    cyc(); instr_ready_i = 1'b1; #1;
    chk("t1_valid", 32'(instr_valid_o), 32'h1);
    chk("t1_instr", instr_o, 32'h13);
    chk("t1_instr_pc", instr_pc_o, 32'h10);
    cyc(); instr_ready_i = 1'b0; pc_load = 1'b1; pc_load_val = 32'h10; #1;
    chk("t1_empty", 32'(instr_valid_o), 32'h0);
    chk("t1_hold_last", instr_o, 32'h13);

    // 2: fill FIFO with decode stalled, then drain
    expect_instr(32'h10, 32'h0000_0013);
    expect_instr(32'h14, 32'h1000_0014);
    expect_instr(32'h18, 32'h1000_0018);
    expect_instr(32'h1C, 32'h1000_001C);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(); pc_load = 1'b0; imem_gnt_i = 1'b1; #1;
      if (imem_req_o && imem_gnt_i) acc++;
    end
    chk("t2_accepts", 32'(acc), 32'd4);
    chk("t2_req_full", 32'(imem_req_o), 32'h0);
    chk("t2_pc_stall", pc_next_o, 32'h20);
    for (int i = 0; i < 4; i++) begin
      cyc(); imem_gnt_i = 1'b0; instr_ready_i = 1'b1; #1;
      chk("t2_drain_valid", 32'(instr_valid_o), 32'h1);
      if (i == 1) chk("t2_resume_req", 32'(imem_req_o), 32'h1);
    end
    cyc(); instr_ready_i = 1'b0; #1;
    chk("t2_drained", 32'(instr_valid_o), 32'h0);

    // 3: no grant for 3 cycles at 0x20
    for (int i = 0; i < 3; i++) begin
      cyc(); imem_gnt_i = 1'b0; #1;
      chk("t3_addr", imem_addr_o, 32'h20);
      chk("t3_pc_next", pc_next_o, 32'h20);
    end

    // 4: redirect with 2 outstanding from 0x30
    cyc(); pc_load = 1'b1; pc_load_val = 32'h30;
    cyc(); pc_load = 1'b0; imem_gnt_i = 1'b1; mem_hold = 1'b1; #1;
    chk("t4_pc_next0", pc_next_o, 32'h34);
    cyc(); #1;
    chk("t4_addr1", imem_addr_o, 32'h34);
    cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h43; #1;
    chk("t4_redirect_req", 32'(imem_req_o), 32'h0);
    chk("t4_redirect_pc", pc_next_o, 32'h40);
    cyc(); redirect_i = 1'b0; mem_hold = 1'b0; #1;
    expect_instr(32'h40, 32'h1000_0040);
    chk("t4_flushed", 32'(instr_valid_o), 32'h0);
    chk("t4_new_addr", imem_addr_o, 32'h40);
    for (int i = 0; i < 3; i++) begin
      cyc(); imem_gnt_i = 1'b0; #1;
      chk("t4_dropping", 32'(instr_valid_o), 32'h0);
    end
    cyc(); instr_ready_i = 1'b1; #1;
    chk("t4_valid", 32'(instr_valid_o), 32'h1);
    chk("t4_first_pc", instr_pc_o, 32'h40);
    cyc(); instr_ready_i = 1'b0; pc_load = 1'b1; pc_load_val = 32'hFFFF_FFFC; #1;
    chk("t4_no_stale", 32'(instr_valid_o), 32'h0);

    // 6: PC wrap at top of address space
    cyc(); pc_load = 1'b0; imem_gnt_i = 1'b1; #1;
    chk("t6_req", 32'(imem_req_o), 32'h1);
    chk("t6_wrap", pc_next_o, 32'h0);
    expect_instr(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    cyc(); imem_gnt_i = 1'b0; #1;
    chk("t6_pc_zero", pc_next_o, 32'h0);
    cyc(); instr_ready_i = 1'b1; #1;
    chk("t6_valid", 32'(instr_valid_o), 32'h1);
    chk("t6_instr_pc", instr_pc_o, 32'hFFFF_FFFC);
    cyc(); instr_ready_i = 1'b0; pc_load = 1'b1; pc_load_val = 32'h50;

    // 5: async reset with 3 entries buffered
    for (int i = 0; i < 3; i++) begin
      cyc(); pc_load = 1'b0; imem_gnt_i = 1'b1;
    end
    cyc(); imem_gnt_i = 1'b0;
    cyc(); #1;
    chk("t5_buffered", 32'(instr_valid_o), 32'h1);
    #1; reset_n = 1'b0; #1;
    chk("t5_valid_async", 32'(instr_valid_o), 32'h0);
    chk("t5_req_async", 32'(imem_req_o), 32'h0);
    chk("t5_instr_async", instr_o, 32'h0);
    chk("t5_pc_next_rst", pc_next_o, 32'h5C);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc(); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
